// File: rtl/barrel_draw_if.sv
// VGA timing/colour bundle shared by the draw-chain stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/barrel_draw.sv
// Rolling-barrel draw stage: per-frame motion FSM plus a 32x32 animated sprite
// overlay from an external synchronous ROM, with 3-cycle timing pass-through.
module barrel_draw #(
  parameter int unsigned SPAWN_X     = 160,
  parameter int unsigned SPAWN_Y     = 128,
  parameter int unsigned X_MIN       = 32,
  parameter int unsigned X_MAX       = 960,
  parameter int unsigned ROLL_STEP   = 2,
  parameter int unsigned FALL_STEP   = 4,
  parameter int unsigned LEVEL_DROP  = 144,
  parameter int unsigned FLOOR_Y     = 704,
  parameter int unsigned ANIM_DIV    = 8,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        spawn,
  input  logic [11:0] rgb_pixel,
  output logic [11:0] pixel_addr,
  output logic        barrel_active,
  output logic [10:0] barrel_x,
  output logic [10:0] barrel_y,
  vga_if.in           in,
  vga_if.out          out
);
  localparam int unsigned XW = 11;
  localparam int unsigned CW = 12;
  localparam int unsigned FW = 8;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ROLL = 2'd1, FALL = 2'd2} state_e;

  typedef struct packed {
    logic [XW-1:0] hcount;
    logic [XW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          hblnk;
    logic          vblnk;
    logic [CW-1:0] rgb;
  } vga_t;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic          dir_q, dir_d, pend_q, pend_d, active_q;
  logic [FW-1:0] fall_q, fall_d;
  logic [1:0]    anim_q, anim_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] addr_q, addr_d;
  vga_t          in_c, s1_q, s2_q, o_q, o_d;

  logic          tick_c, at_limit_c, fall_done_c, hit_c;
  logic [XW-1:0] roll_x_c, hx_c, hy_c;
  logic [FW-1:0] fall_sum_c;

  assign in_c = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};

  // Frame tick and motion helpers shared by next-state and datapath logic.
  assign tick_c      = (in.vcount == XW'(0)) && (in.hcount == XW'(0));
  assign roll_x_c    = dir_q ? (x_q - XW'(ROLL_STEP)) : (x_q + XW'(ROLL_STEP));
  assign at_limit_c  = dir_q ? (roll_x_c <= XW'(X_MIN)) : (roll_x_c >= XW'(X_MAX));
  assign fall_sum_c  = fall_q + FW'(FALL_STEP);
  assign fall_done_c = fall_sum_c >= FW'(LEVEL_DROP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!start_game) begin
      state_d = IDLE;
    end else if (tick_c) begin
      case (state_q)
        IDLE:    if (pend_q) state_d = ROLL;
        ROLL:    if (at_limit_c) state_d = (y_q >= XW'(FLOOR_Y)) ? IDLE : FALL;
        FALL:    if (fall_done_c) state_d = ROLL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    dir_d  = dir_q;
    fall_d = fall_q;
    anim_d = anim_q;
    div_d  = div_q;
    pend_d = pend_q;

    // A spawn is only remembered while idle; the tick that launches it consumes it.
    if (!start_game)                           pend_d = 1'b0;
    else if (tick_c && state_q == IDLE && pend_q) pend_d = 1'b0;
    else if (spawn && state_q == IDLE)         pend_d = 1'b1;

    if (start_game && tick_c) begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            x_d    = XW'(SPAWN_X);
            y_d    = XW'(SPAWN_Y);
            dir_d  = 1'b0;
            anim_d = 2'd0;
            div_d  = '0;
          end
        end
        ROLL: begin
          x_d = roll_x_c;
          if (at_limit_c) begin
            x_d    = dir_q ? XW'(X_MIN) : XW'(X_MAX);
            fall_d = '0;
          end
          if (div_q == DW'(ANIM_DIV - 1)) begin
            div_d  = '0;
            anim_d = dir_q ? (anim_q - 2'd1) : (anim_q + 2'd1);
          end else begin
            div_d  = div_q + DW'(1);
          end
        end
        FALL: begin
          y_d    = y_q + XW'(FALL_STEP);
          fall_d = fall_sum_c;
          if (fall_done_c) dir_d = ~dir_q;
        end
        default: ;
      endcase
    end
  end

  // Sprite fetch address from undelayed counts; ROM data lines up with stage 2.
  assign addr_d = {anim_q, 5'(in.vcount - y_q), 5'(in.hcount - x_q)};

  assign hx_c  = s2_q.hcount - x_q;
  assign hy_c  = s2_q.vcount - y_q;
  assign hit_c = (state_q != IDLE) &&
                 (s2_q.hcount >= x_q) && (hx_c[XW-1:5] == '0) &&
                 (s2_q.vcount >= y_q) && (hy_c[XW-1:5] == '0) &&
                 !s2_q.hblnk && !s2_q.vblnk;

  always_comb begin
    o_d = s2_q;
    if (hit_c && rgb_pixel != TRANSPARENT) o_d.rgb = rgb_pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= 1'b0;
      pend_q   <= 1'b0;
      active_q <= 1'b0;
      fall_q   <= '0;
      anim_q   <= '0;
      div_q    <= '0;
      addr_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      o_q      <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      active_q <= (state_d != IDLE);
      fall_q   <= fall_d;
      anim_q   <= anim_d;
      div_q    <= div_d;
      addr_q   <= addr_d;
      s1_q     <= in_c;
      s2_q     <= s1_q;
      o_q      <= o_d;
    end
  end

  assign out.hcount    = o_q.hcount;
  assign out.vcount    = o_q.vcount;
  assign out.hsync     = o_q.hsync;
  assign out.vsync     = o_q.vsync;
  assign out.hblnk     = o_q.hblnk;
  assign out.vblnk     = o_q.vblnk;
  assign out.rgb       = o_q.rgb;
  assign pixel_addr    = addr_q;
  assign barrel_active = active_q;
  assign barrel_x      = x_q;
  assign barrel_y      = y_q;
endmodule
